fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Downstream drain stage for the synchronous FIFO. Issues read enables against the FIFO's empty flag and absorbs the FIFO's 1-cycle registered read latency.
- Presents the data as a valid/ready stream framed into fixed-length bursts with first/last markers.
- Sits between the sync FIFO read port and the consumer (packet builder or DMA writer).

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- BURST_LEN, 16, beats per burst; any value ≥1, power of two not required.
- CNT_WIDTH, 16, width of the completed-burst counter.

Ports:
- i_sys_clk  in  1  clock.
- i_sys_rst_n  in  1  reset.
- i_enable  in  1  level; 1 = keep draining bursts.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_rdata  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
- o_fifo_rden  out  1  FIFO read enable.
- o_m_data  out  DATA_WIDTH  stream data.
- o_m_valid  out  1  stream valid.
- i_m_ready  in  1  stream ready.
- o_m_first  out  1  first beat of burst.
- o_m_last  out  1  last beat of burst.
- o_busy  out  1  state != IDLE.
- o_burst_cnt  out  CNT_WIDTH  completed bursts, wraps.

Behaviour:
- Reset: i_sys_clk is the clock; i_sys_rst_n is the reset, asynchronous, active-low.
  - All outputs reset to 0; state IDLE; counters 0; buffer empty; inflight = 0.
  - The same reset drives the FIFO, so reset mid-burst discards the partial burst. No recovery is attempted.
- FIFO read model: a read is accepted when o_fifo_rden=1 and i_fifo_empty=0. Set inflight <= accepted. The next cycle, i_fifo_rdata is pushed into the skid buffer.
- Skid buffer: 3 entries, circular, fully registered.
  - occ counts 0..3.
  - Pop when o_m_valid && i_m_ready.
  - Push and pop in the same cycle: occ unchanged.
- o_fifo_rden = (state==RUN) && !i_fifo_empty && (occ + inflight < 3) && issue-gate.
  - No combinational path from i_m_ready to o_fifo_rden.
  - Sustains 1 beat/cycle with ready held high.
- States:
  - IDLE: no reads. Go to RUN when i_enable=1.
  - RUN: reads allowed.
    - issue_cnt counts accepted reads 0..BURST_LEN-1 and wraps to 0 after BURST_LEN.
    - If i_enable=0 and issue_cnt==0, go to DRAIN. issue-gate=0 in that cycle.
    - If i_enable drops mid-burst, reads continue until the burst's BURST_LEN reads are issued. Then go to DRAIN.
    - Outgoing bursts are therefore always complete.
  - DRAIN: no reads. Go to IDLE when occ==0 && inflight==0. i_enable during DRAIN is ignored until IDLE.
- Stream (valid/ready):
  - o_m_valid = (occ != 0). o_m_data = head entry.
  - While valid && !ready, o_m_data, o_m_first and o_m_last hold stable, and valid does not drop.
- Framing:
  - out_cnt counts popped beats 0..BURST_LEN-1 and wraps.
  - o_m_first = valid && out_cnt==0.
  - o_m_last = valid && out_cnt==BURST_LEN-1.
  - BURST_LEN=1: first and last are both high on every beat.
- o_burst_cnt increments on a pop with o_m_last=1. Wraps 2^CNT_WIDTH-1 -> 0.
- FIFO empties mid-burst: reads stall, o_m_valid drops when the buffer runs dry, and the burst resumes when data returns. first/last positions are unaffected.
- Latency: FIFO non-empty in RUN -> rden same cycle -> o_m_valid 2 cycles after that rden.

Test Plan:
- FIFO preloaded with 32 words 0x00..0x1F, BURST_LEN=16, enable=1, ready=1 -> rden continuous, 32 consecutive beats. first on 0x00 and 0x10; last on 0x0F and 0x1F. burst_cnt=2.
- Ready toggles 1/0 every cycle during the 32-word transfer -> data sequence unchanged, no duplicates or drops. occ never exceeds 3. Data and first/last stable while stalled.
- FIFO holds 5 words; 11 more written 20 cycles later -> valid gap after beat 5. last asserts only on the 16th beat (0x0F). burst_cnt=1.
- Enable deasserted after the 3rd read of a burst, FIFO has 40 words -> exactly 16 reads issued, DRAIN, then IDLE with busy=0. FIFO retains 24 words.
- Reset asserted mid-burst (beat 7 on the stream) -> all outputs 0 immediately, state IDLE. After release with enable=1, the next beat has first=1.
- BURST_LEN=1, 4 words, and burst_cnt forced near wrap with CNT_WIDTH=2 -> first=last=1 on every beat; burst_cnt goes 0,1,2,3,0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Brief    : Drains a sync FIFO through a 3-entry skid buffer and emits the
//            words as a valid/ready stream framed into fixed-length bursts.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
    output logic                  o_fifo_rden,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic                  o_m_first,
    output logic                  o_m_last,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_burst_cnt
);

    localparam int              C_IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [1:0]             occ_q,       occ_d;
    logic [1:0]             wr_ptr_q,    wr_ptr_d;
    logic [1:0]             rd_ptr_q,    rd_ptr_d;
    logic                   inflight_q,  inflight_d;
    logic [C_IDX_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [C_IDX_W-1:0]     out_cnt_q,   out_cnt_d;
    logic [CNT_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0]  buf_q [3];
    logic [DATA_WIDTH-1:0]  buf_d [3];

    logic w_valid;
    logic w_last;
    logic w_pop;
    logic w_push;
    logic w_rden;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        w_valid = (occ_q != 2'd0);
        w_last  = w_valid && (out_cnt_q == C_LAST_IDX);
        w_pop   = w_valid && i_m_ready;
        w_push  = inflight_q;
        // Credit check counts the word still in flight from the FIFO, so the
        // buffer can never overflow and ready never reaches the read enable.
        w_rden  = (state_q == RUN) && !i_fifo_empty
                  && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3)
                  && !(!i_enable && (issue_cnt_q == '0));

        state_d     = state_q;
        occ_d       = occ_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = w_rden;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        burst_cnt_d = burst_cnt_q;
        buf_d       = buf_q;

        if (w_push) begin
            buf_d[wr_ptr_q] = i_fifo_rdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            out_cnt_d = (out_cnt_q == C_LAST_IDX) ? '0 : out_cnt_q + 1'b1;
            if (w_last) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
        end
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        if (w_rden) begin
            issue_cnt_d = (issue_cnt_q == C_LAST_IDX) ? '0 : issue_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE:    if (i_enable) state_d = RUN;
            RUN:     if (!i_enable && (issue_cnt_q == '0)) state_d = DRAIN;
            DRAIN:   if ((occ_q == 2'd0) && !inflight_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q     <= IDLE;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            inflight_q  <= 1'b0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            burst_cnt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            buf_q       <= buf_d;
        end
    end

    assign o_fifo_rden = w_rden;
    assign o_m_valid   = w_valid;
    assign o_m_data    = buf_q[rd_ptr_q];
    assign o_m_first   = w_valid && (out_cnt_q == '0);
    assign o_m_last    = w_last;
    assign o_busy      = (state_q != IDLE);
    assign o_burst_cnt = burst_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_reader
// Brief    : Directed bench with a behavioural sync FIFO feeding two readers
//            (BURST_LEN=16/CNT_WIDTH=16 and BURST_LEN=1/CNT_WIDTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en0   = 1'b0;
    logic en1   = 1'b0;
    logic rdy0  = 1'b1;
    logic rdy1  = 1'b1;

    logic [1:0]      f_rden;
    logic [1:0]      f_empty;
    logic [1:0]      f_wr    = '0;
    logic [1:0][7:0] f_wdata = '0;
    logic [1:0][7:0] f_rdata;

    logic [7:0]  d0, d1;
    logic        v0, v1, fst0, fst1, lst0, lst1, busy0, busy1;
    logic [15:0] bc0;
    logic [1:0]  bc1;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int rd_acc = 0;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
        int         cyc;
        int         cnt;
    } beat_t;
    beat_t beats0[$];
    beat_t beats1[$];

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(16), .CNT_WIDTH(16)) dut0 (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_enable(en0),
        .i_fifo_empty(f_empty[0]), .i_fifo_rdata(f_rdata[0]), .o_fifo_rden(f_rden[0]),
        .o_m_data(d0), .o_m_valid(v0), .i_m_ready(rdy0), .o_m_first(fst0),
        .o_m_last(lst0), .o_busy(busy0), .o_burst_cnt(bc0)
    );

    fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(2)) dut1 (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_enable(en1),
        .i_fifo_empty(f_empty[1]), .i_fifo_rdata(f_rdata[1]), .o_fifo_rden(f_rden[1]),
        .o_m_data(d1), .o_m_valid(v1), .i_m_ready(rdy1), .o_m_first(fst1),
        .o_m_last(lst1), .o_busy(busy1), .o_burst_cnt(bc1)
    );

    // Sync FIFO with registered read data, cleared by the shared reset
    for (genvar k = 0; k < 2; k++) begin : g_fifo
        logic [7:0] mem [64];
        logic [7:0] rdata;
        int         wp, rp, cnt;
        logic       rd;
        assign rd = f_rden[k] && (cnt != 0);
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp <= 0; rp <= 0; cnt <= 0; rdata <= '0;
            end else begin
                if (f_wr[k]) begin
                    mem[wp % 64] <= f_wdata[k];
                    wp           <= wp + 1;
                end
                if (rd) begin
                    rdata <= mem[rp % 64];
                    rp    <= rp + 1;
                end
                cnt <= cnt + (f_wr[k] ? 1 : 0) - (rd ? 1 : 0);
            end
        end
        assign f_empty[k] = (cnt == 0);
        assign f_rdata[k] = rdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic       stall_q = 1'b0;
    logic [9:0] prev_q  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 32'(v0), 32'd1);
                check("stall_hold", 32'({fst0, lst0, d0}), 32'(prev_q));
            end
            if (v0 && rdy0) beats0.push_back('{d: d0, f: fst0, l: lst0, cyc: cyc, cnt: int'(bc0)});
            if (v1 && rdy1) beats1.push_back('{d: d1, f: fst1, l: lst1, cyc: cyc, cnt: int'(bc1)});
            if (f_rden[0] && !f_empty[0]) rd_acc <= rd_acc + 1;
            stall_q <= v0 && !rdy0;
            prev_q  <= {fst0, lst0, d0};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; rdy0 = 1'b1; f_wr = '0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic fifo_write(input int k, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            f_wr[k]    = 1'b1;
            f_wdata[k] = 8'(base + i);
            step();
        end
        f_wr[k] = 1'b0;
    endtask

    task automatic chk_seq(input string tag, input int b0, input int n, input int base);
        check({tag, "_count"}, 32'(beats0.size() - b0), 32'(n));
        for (int i = 0; i < n && (b0 + i) < beats0.size(); i++) begin
            check(tag, 32'({beats0[b0+i].f, beats0[b0+i].l, beats0[b0+i].d}),
                  32'({(i % 16 == 0), (i % 16 == 15), 8'(base + i)}));
        end
    endtask

    initial begin
        int b0;
        int ra;

        // Reset state
        step(); step();
        check("rst_outs0", 32'({d0, v0, fst0, lst0, busy0, f_rden[0], bc0}), 32'd0);
        check("rst_outs1", 32'({d1, v1, fst1, lst1, busy1, f_rden[1], bc1}), 32'd0);
        rst_n = 1'b1;
        step();

        // Continuous 32-word drain, ready held high
        fifo_write(0, 32, 0);
        b0 = beats0.size();
        ra = rd_acc;
        en0 = 1'b1;
        for (int t = 0; t < 100 && bc0 != 16'd2; t++) step();
        check("t1_burst_cnt", 32'(bc0), 32'd2);
        chk_seq("t1_beat", b0, 32, 0);
        if (beats0.size() >= b0 + 32)
            check("t1_back_to_back", 32'(beats0[b0+31].cyc - beats0[b0].cyc), 32'd31);
        check("t1_reads", 32'(rd_acc - ra), 32'd32);
        en0 = 1'b0;
        for (int t = 0; t < 20 && busy0; t++) step();
        check("t1_idle", 32'(busy0), 32'd0);

        // Ready toggling every cycle
        do_reset();
        fifo_write(0, 32, 0);
        b0 = beats0.size();
        en0 = 1'b1;
        for (int t = 0; t < 300 && bc0 != 16'd2; t++) begin
            rdy0 = ~rdy0;
            step();
        end
        rdy0 = 1'b1;
        check("t2_burst_cnt", 32'(bc0), 32'd2);
        chk_seq("t2_beat", b0, 32, 0);

        // FIFO runs dry after 5 words, refilled 20 cycles later
        do_reset();
        fifo_write(0, 5, 0);
        b0 = beats0.size();
        en0 = 1'b1;
        repeat (15) step();
        check("t3_gap_valid", 32'({v0, busy0}), 32'b01);
        repeat (5) step();
        fifo_write(0, 11, 5);
        for (int t = 0; t < 50 && bc0 != 16'd1; t++) step();
        check("t3_burst_cnt", 32'(bc0), 32'd1);
        chk_seq("t3_beat", b0, 16, 0);
        if (beats0.size() >= b0 + 6)
            check("t3_gap_seen", 32'(beats0[b0+5].cyc - beats0[b0+4].cyc > 1), 32'd1);

        // Enable dropped after the 3rd read: burst completes, then idle
        do_reset();
        fifo_write(0, 40, 0);
        b0 = beats0.size();
        ra = rd_acc;
        en0 = 1'b1;
        for (int t = 0; t < 20 && (rd_acc - ra) < 3; t++) step();
        check("t4_three_reads", 32'(rd_acc - ra), 32'd3);
        en0 = 1'b0;
        step();
        check("t4_busy_mid", 32'(busy0), 32'd1);
        for (int t = 0; t < 100 && busy0; t++) step();
        check("t4_idle", 32'({busy0, v0}), 32'd0);
        check("t4_reads", 32'(rd_acc - ra), 32'd16);
        check("t4_fifo_left", 32'(g_fifo[0].cnt), 32'd24);
        check("t4_burst_cnt", 32'(bc0), 32'd1);
        chk_seq("t4_beat", b0, 16, 0);

        // Reset while beat 7 is on the stream
        do_reset();
        fifo_write(0, 32, 8'h40);
        b0 = beats0.size();
        en0 = 1'b1;
        for (int t = 0; t < 50 && (beats0.size() - b0) < 6; t++) step();
        check("t5_pre_beat7", 32'({v0, fst0, lst0, d0}), 32'({1'b1, 1'b0, 1'b0, 8'h46}));
        rst_n = 1'b0;
        #1;
        check("t5_rst_outs", 32'({d0, v0, fst0, lst0, busy0, f_rden[0], bc0}), 32'd0);
        step();
        rst_n = 1'b1;
        b0 = beats0.size();
        fifo_write(0, 4, 8'hA0);
        for (int t = 0; t < 20 && beats0.size() == b0; t++) step();
        check("t5_seen", 32'(beats0.size() > b0), 32'd1);
        if (beats0.size() > b0)
            check("t5_first_after", 32'({beats0[b0].f, beats0[b0].l, beats0[b0].d}),
                  32'({1'b1, 1'b0, 8'hA0}));

        // BURST_LEN=1 with a 2-bit burst counter that wraps
        do_reset();
        check("t6_cnt_rst", 32'(bc1), 32'd0);
        fifo_write(1, 4, 8'h10);
        b0 = beats1.size();
        en1 = 1'b1;
        for (int t = 0; t < 30 && (beats1.size() - b0) < 4; t++) step();
        step();
        check("t6_count", 32'(beats1.size() - b0), 32'd4);
        for (int i = 0; i < 4 && (b0 + i) < beats1.size(); i++) begin
            check("t6_beat", 32'({beats1[b0+i].f, beats1[b0+i].l, beats1[b0+i].d}),
                  32'({1'b1, 1'b1, 8'(8'h10 + i)}));
            check("t6_cnt_seq", 32'(beats1[b0+i].cnt), 32'(i));
        end
        check("t6_cnt_wrap", 32'(bc1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
